axi4_burst_master: RTL

Parametrised second-generation AXI4 master engine that issues one write or read burst per accepted command. Burst length is runtime-selectable and FIXED, INCR and WRAP bursts are all supported. Commands are legality-checked before any bus activity, and B/R responses are collected into a status word. Sits between a local command/data-stream client and the AXI4 interconnect, replacing the fixed-length master FSM.

---
 rtl/axi4_pkg.sv | 34 +++
 rtl/axi4_burst_master_if.sv | 54 +++++
 rtl/axi4_burst_check.sv | 40 ++++
 rtl/axi4_burst_master.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/axi4_pkg.sv
// Shared definitions for the AXI4 burst master.
//   - burst and response encodings
//   - FSM state type
//   - 4 KB boundary constant and the worst-response merge
package axi4_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int BOUNDARY_4K = 4096;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_AW_REQ,
        ST_W_DATA,
        ST_B_WAIT,
        ST_AR_REQ,
        ST_R_DATA
    } state_t;

    // The numeric order of the encodings already ranks them, so EXOKAY
    // can never displace SLVERR/DECERR.
    function automatic logic [1:0] worst_resp(input logic [1:0] cur, input logic [1:0] nxt);
        return (nxt > cur) ? nxt : cur;
    endfunction

endpackage

// File: rtl/axi4_burst_master_if.sv
// AXI4 bus bundle (AW, W, B, AR, R channels) between the burst master and
// the interconnect.
//   master modport: drives valids/payloads of AW/W/AR and bready/rready
//   slave modport : the opposite directions
interface axi4_burst_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128
);
    logic                  awvalid;
    logic                  awready;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;

    logic                  wvalid;
    logic                  wready;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wlast;

    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;

    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;

    logic                  rvalid;
    logic                  rready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;

    modport master (
        output awvalid, awaddr, awlen, awsize, awburst, input awready,
        output wvalid, wdata, wlast, input wready,
        input  bvalid, bresp, output bready,
        output arvalid, araddr, arlen, arsize, arburst, input arready,
        input  rvalid, rdata, rresp, rlast, output rready
    );

    modport slave (
        input  awvalid, awaddr, awlen, awsize, awburst, output awready,
        input  wvalid, wdata, wlast, output wready,
        output bvalid, bresp, input bready,
        input  arvalid, araddr, arlen, arsize, arburst, output arready,
        output rvalid, rdata, rresp, rlast, input rready
    );

endinterface

// File: rtl/axi4_burst_check.sv
// Combinational legality check for one burst command.
//   addr  : start byte address
//   len   : beats-1
//   burst : FIXED/INCR/WRAP encoding
//   legal : 1 when the command may be issued on the bus
module axi4_burst_check
    import axi4_pkg::*;
#(
    parameter int ADDR_WIDTH    = 32,
    parameter int BYTES         = 16,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [7:0]            len,
    input  logic [1:0]            burst,
    output logic                  legal
);

    logic        too_long;
    logic        bad_burst;
    logic        wrap_bad;
    logic        fixed_bad;
    logic        misaligned;
    logic        cross_4k;
    logic [31:0] end_off;

    assign too_long   = ({1'b0, len} + 9'd1) > 9'(MAX_BURST_LEN);
    assign bad_burst  = (burst == 2'b11);
    assign wrap_bad   = (burst == BURST_WRAP) &&
                        !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
    assign fixed_bad  = (burst == BURST_FIXED) && (len > 8'd15);
    assign misaligned = (addr & ADDR_WIDTH'(BYTES - 1)) != '0;

    // Offset of the first byte past the burst, relative to its 4 KB page.
    assign end_off    = 32'(addr[11:0]) + (32'(len) + 32'd1) * 32'(BYTES);
    assign cross_4k   = (burst == BURST_INCR) && (end_off > 32'(BOUNDARY_4K));

    assign legal = !(too_long || bad_burst || wrap_bad || fixed_bad || misaligned || cross_4k);

endmodule

// File: rtl/axi4_burst_master.sv
// AXI4 master issuing one write or read burst per accepted command.
// Optional build macro: AXI4_MASTER_PERF_EN (adds the perf_cycles counter;
// without it perf_cycles is tied to 0).
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   cmd_*                   command request (addr, len, burst, rw)
//   wr_data/valid/ready     write payload stream from the client
//   rd_data/valid/last/ready read data stream to the client
//   done, done_resp         completion pulse and worst response
//   cmd_err                 pulse on a rejected command
//   perf_cycles             cycles from CHECK exit to done
//   axi                     AXI4 master bus
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | waiting for a command, cmd_ready high
// ST_CHECK  | registered command is checked for legality
// ST_AW_REQ | write address offered until awready
// ST_W_DATA | write beats streamed from the client
// ST_B_WAIT | waiting for the write response
// ST_AR_REQ | read address offered until arready
// ST_R_DATA | read beats streamed to the client
module axi4_burst_master
    import axi4_pkg::*;
#(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 128,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [1:0]            cmd_burst,
    input  logic                  cmd_rw,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_last,
    input  logic                  rd_ready,
    output logic                  done,
    output logic [1:0]            done_resp,
    output logic                  cmd_err,
    output logic [31:0]           perf_cycles,
    axi4_burst_master_if.master   axi
);

    localparam int         BYTES = DATA_WIDTH / 8;
    localparam logic [2:0] SIZE  = 3'($clog2(BYTES));

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [1:0]            burst_q;
    logic                  rw_q;
    logic [7:0]            beat_cnt;
    logic [1:0]            resp_acc;
    logic                  len_err;
    logic                  legal;
    logic                  w_hs;
    logic                  r_hs;
    logic                  finish;

    axi4_burst_check #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .BYTES         (BYTES),
        .MAX_BURST_LEN (MAX_BURST_LEN)
    ) u_check (
        .addr  (addr_q),
        .len   (len_q),
        .burst (burst_q),
        .legal (legal)
    );

    assign w_hs   = (state == ST_W_DATA) && wr_valid && axi.wready;
    assign r_hs   = (state == ST_R_DATA) && axi.rvalid && rd_ready;
    assign finish = ((state == ST_B_WAIT) && axi.bvalid) || (r_hs && axi.rlast);

    assign axi.awaddr  = addr_q;
    assign axi.awlen   = len_q;
    assign axi.awburst = burst_q;
    assign axi.awsize  = SIZE;
    assign axi.araddr  = addr_q;
    assign axi.arlen   = len_q;
    assign axi.arburst = burst_q;
    assign axi.arsize  = SIZE;
    assign axi.wdata   = wr_data;
    assign rd_data     = axi.rdata;
    assign rd_last     = axi.rlast;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        cmd_ready   = 1'b0;
        cmd_err     = 1'b0;
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
        axi.wlast   = 1'b0;
        wr_ready    = 1'b0;
        axi.bready  = 1'b0;
        axi.arvalid = 1'b0;
        axi.rready  = 1'b0;
        rd_valid    = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                if (!legal) begin
                    cmd_err   = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = rw_q ? ST_AR_REQ : ST_AW_REQ;
                end
            end
            ST_AW_REQ: begin
                axi.awvalid = 1'b1;
                if (axi.awready) state_nxt = ST_W_DATA;
            end
            ST_W_DATA: begin
                axi.wvalid = wr_valid;
                wr_ready   = axi.wready;
                axi.wlast  = (beat_cnt == len_q);
                if (w_hs && (beat_cnt == len_q)) state_nxt = ST_B_WAIT;
            end
            ST_B_WAIT: begin
                axi.bready = 1'b1;
                if (axi.bvalid) state_nxt = ST_IDLE;
            end
            ST_AR_REQ: begin
                axi.arvalid = 1'b1;
                if (axi.arready) state_nxt = ST_R_DATA;
            end
            ST_R_DATA: begin
                axi.rready = rd_ready;
                rd_valid   = axi.rvalid;
                if (r_hs && axi.rlast) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q    <= '0;
            len_q     <= '0;
            burst_q   <= '0;
            rw_q      <= 1'b0;
            beat_cnt  <= '0;
            resp_acc  <= RESP_OKAY;
            len_err   <= 1'b0;
            done      <= 1'b0;
            done_resp <= RESP_OKAY;
        end else begin
            done <= finish;
            if (state == ST_IDLE && cmd_valid) begin
                addr_q   <= cmd_addr;
                len_q    <= cmd_len;
                burst_q  <= cmd_burst;
                rw_q     <= cmd_rw;
                beat_cnt <= '0;
                resp_acc <= RESP_OKAY;
                len_err  <= 1'b0;
            end
            if (w_hs) beat_cnt <= beat_cnt + 8'd1;
            if (state == ST_B_WAIT && axi.bvalid) done_resp <= axi.bresp;
            if (r_hs) begin
                beat_cnt <= beat_cnt + 8'd1;
                resp_acc <= worst_resp(resp_acc, axi.rresp);
                // Final beat reached without rlast: keep reading until rlast,
                // but the transaction is reported as failed.
                if (beat_cnt == len_q && !axi.rlast) len_err <= 1'b1;
                if (axi.rlast) begin
                    done_resp <= (len_err || beat_cnt != len_q) ? RESP_SLVERR
                                                                : worst_resp(resp_acc, axi.rresp);
                end
            end
        end
    end

`ifdef AXI4_MASTER_PERF_EN
    logic [31:0] perf_cnt;
    logic [31:0] perf_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_cnt <= '0;
            perf_q   <= '0;
        end else begin
            if (state == ST_CHECK)    perf_cnt <= '0;
            else if (perf_cnt != '1)  perf_cnt <= perf_cnt + 32'd1;
            if (finish) perf_q <= (perf_cnt == '1) ? perf_cnt : perf_cnt + 32'd1;
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = '0;
`endif

endmodule
